// File: rtl/seu_mon_rdout_arb.sv
// Multi-lane SEU error-monitor readout: per-lane rising-edge capture with hit counts and timestamps,
// round-robin arbitration into a single registered FIFO write port, with run framing and heartbeats.
module seu_mon_rdout_arb #(
    parameter int unsigned LANES_G         = 2,
    parameter int unsigned READOUT_WIDTH_G = 32,
    parameter int unsigned HB_PERIOD_G     = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       enable_i,
    input  logic [LANES_G-1:0]         monitor_i,
    input  logic                       fifo_full_i,
    input  logic                       fifo_almst_full_i,
    output logic                       fifo_wr_o,
    output logic [READOUT_WIDTH_G-1:0] fifo_data_o,
    output logic                       busy_o,
    output logic [15:0]                drop_cnt_o
);

    localparam int unsigned PTR_W    = (LANES_G > 1) ? $clog2(LANES_G) : 1;
    localparam logic [31:0] HB_LAST  = (HB_PERIOD_G > 0) ? 32'(HB_PERIOD_G - 1) : 32'd0;
    localparam logic [5:0]  LANE_MAX = 6'(LANES_G - 1);
    localparam logic [15:0] HB_FIELD = 16'(HB_PERIOD_G);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t             state_q, state_d;
    logic [LANES_G-1:0] mon_q, mon_d;
    logic [LANES_G-1:0] pending_q, pending_d;
    logic [7:0]         hit_q    [LANES_G];
    logic [7:0]         hit_d    [LANES_G];
    logic [15:0]        cap_ts_q [LANES_G];
    logic [15:0]        cap_ts_d [LANES_G];
    logic [31:0]        ts_q, ts_d;
    logic [31:0]        div_q, div_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               start_pend_q, start_pend_d;
    logic               trl_pend_q, trl_pend_d;
    logic               hb_pend_q, hb_pend_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               fifo_wr_q, fifo_wr_d;
    logic [31:0]        fifo_data_q, fifo_data_d;

    logic [LANES_G-1:0] rise;
    logic               can_wr;
    logic               gnt_start, gnt_trl, gnt_hb, gnt_lane;
    logic               lane_hi_vld, lane_lo_vld;
    logic [PTR_W-1:0]   lane_hi_idx, lane_lo_idx, lane_idx;
    logic [16:0]        drop_sum;

    assign rise = monitor_i & ~mon_q;
    assign mon_d = monitor_i;

    // Round-robin: lowest pending lane above ptr wins, else wrap to lowest pending lane at or below ptr.
    always_comb begin
        lane_hi_vld = 1'b0;
        lane_lo_vld = 1'b0;
        lane_hi_idx = '0;
        lane_lo_idx = '0;
        for (int l = int'(LANES_G) - 1; l >= 0; l--) begin
            if (pending_q[l] && (l > int'(ptr_q))) begin
                lane_hi_vld = 1'b1;
                lane_hi_idx = PTR_W'(l);
            end
            if (pending_q[l] && (l <= int'(ptr_q))) begin
                lane_lo_vld = 1'b1;
                lane_lo_idx = PTR_W'(l);
            end
        end
        lane_idx = lane_hi_vld ? lane_hi_idx : lane_lo_idx;
    end

    assign can_wr    = (state_q != S_IDLE) && !fifo_almst_full_i && !fifo_full_i;
    assign gnt_start = can_wr && start_pend_q;
    assign gnt_trl   = can_wr && !start_pend_q && trl_pend_q;
    assign gnt_hb    = can_wr && !start_pend_q && !trl_pend_q && hb_pend_q;
    assign gnt_lane  = can_wr && !start_pend_q && !trl_pend_q && !hb_pend_q
                       && (lane_hi_vld || lane_lo_vld);

    // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        hit_d        = hit_q;
        cap_ts_d     = cap_ts_q;
        ts_d         = ts_q;
        div_d        = div_q;
        ptr_d        = ptr_q;
        start_pend_d = start_pend_q && !gnt_start;
        trl_pend_d   = trl_pend_q && !gnt_trl;
        hb_pend_d    = hb_pend_q && !gnt_hb;
        drop_sum     = {1'b0, drop_cnt_q};
        fifo_wr_d    = 1'b0;
        fifo_data_d  = fifo_data_q;

        if (gnt_start) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = {2'b10, LANE_MAX, 8'h00, HB_FIELD};
        end else if (gnt_trl) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = {2'b11, 14'd0, drop_cnt_q};
        end else if (gnt_hb) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = {2'b01, ts_q[29:0]};
        end else if (gnt_lane) begin
            fifo_wr_d            = 1'b1;
            fifo_data_d          = {2'b00, 6'(lane_idx), hit_q[lane_idx], cap_ts_q[lane_idx]};
            pending_d[lane_idx]  = 1'b0;
            ptr_d                = lane_idx;
        end

        unique case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d      = S_RUN;
                    start_pend_d = 1'b1;
                    ts_d         = '0;
                    div_d        = '0;
                    hit_d        = '{default: '0};
                    drop_sum     = '0;
                end
            end
            S_RUN: begin
                ts_d = ts_q + 32'd1;
                for (int l = 0; l < int'(LANES_G); l++) begin
                    if (rise[l]) begin
                        // A new edge on a still-pending lane overwrites it; losing the older event is a drop.
                        if (pending_q[l] && !(gnt_lane && (lane_idx == PTR_W'(l))))
                            drop_sum = drop_sum + 17'd1;
                        pending_d[l] = 1'b1;
                        cap_ts_d[l]  = ts_q[15:0];
                        if (hit_q[l] != 8'hFF)
                            hit_d[l] = hit_q[l] + 8'd1;
                    end
                end
                if (HB_PERIOD_G != 0) begin
                    if (div_q == HB_LAST) begin
                        div_d     = '0;
                        hb_pend_d = 1'b1;
                    end else begin
                        div_d = div_q + 32'd1;
                    end
                end
                if (!enable_i) begin
                    state_d   = S_STOP;
                    hb_pend_d = 1'b0;
                end
            end
            S_STOP: begin
                ts_d = ts_q + 32'd1;
                if ((pending_q == '0) && !start_pend_q && !trl_pend_q)
                    trl_pend_d = 1'b1;
                if (gnt_trl)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // NOTE: the per-lane arrays are small register files, so they are reset along with the rest of the state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            mon_q        <= '0;
            pending_q    <= '0;
            hit_q        <= '{default: '0};
            cap_ts_q     <= '{default: '0};
            ts_q         <= '0;
            div_q        <= '0;
            ptr_q        <= '0;
            start_pend_q <= 1'b0;
            trl_pend_q   <= 1'b0;
            hb_pend_q    <= 1'b0;
            drop_cnt_q   <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mon_q        <= mon_d;
            pending_q    <= pending_d;
            hit_q        <= hit_d;
            cap_ts_q     <= cap_ts_d;
            ts_q         <= ts_d;
            div_q        <= div_d;
            ptr_q        <= ptr_d;
            start_pend_q <= start_pend_d;
            trl_pend_q   <= trl_pend_d;
            hb_pend_q    <= hb_pend_d;
            drop_cnt_q   <= drop_cnt_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    assign fifo_wr_o   = fifo_wr_q;
    assign fifo_data_o = READOUT_WIDTH_G'(fifo_data_q);
    assign busy_o      = (state_q != S_IDLE);
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_seu_mon_rdout_arb.sv
// Directed bench for seu_mon_rdout_arb: a default instance (2 lanes, heartbeat 1024) for framing,
// arbitration, backpressure and drops, plus a heartbeat-8 instance for periodic heartbeat words.
module tb_seu_mon_rdout_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        en_hb;
    logic [1:0]  mon;
    logic [1:0]  mon_hb;
    logic        full;
    logic        af;

    logic        wr;
    logic [31:0] data;
    logic        busy;
    logic [15:0] drop;

    logic        wr_hb;
    logic [31:0] data_hb;
    logic        busy_hb;
    logic [15:0] drop_hb;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seu_mon_rdout_arb #(.LANES_G(2), .READOUT_WIDTH_G(32), .HB_PERIOD_G(1024)) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .enable_i          (enable),
        .monitor_i         (mon),
        .fifo_full_i       (full),
        .fifo_almst_full_i (af),
        .fifo_wr_o         (wr),
        .fifo_data_o       (data),
        .busy_o            (busy),
        .drop_cnt_o        (drop)
    );

    seu_mon_rdout_arb #(.LANES_G(2), .READOUT_WIDTH_G(32), .HB_PERIOD_G(8)) dut_hb (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .enable_i          (en_hb),
        .monitor_i         (mon_hb),
        .fifo_full_i       (full),
        .fifo_almst_full_i (af),
        .fifo_wr_o         (wr_hb),
        .fifo_data_o       (data_hb),
        .busy_o            (busy_hb),
        .drop_cnt_o        (drop_hb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b1; enable = 1'b0; en_hb = 1'b0;
        mon = '0; mon_hb = '0; full = 1'b0; af = 1'b0;
        #2 rst_n = 1'b0;
        step(2);
        check("rst_wr",   32'(wr),   32'd0);
        check("rst_data", data,      32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("idle_busy", 32'(busy), 32'd0);

        // Run start: header one cycle after RUN entry.
        enable = 1'b1;
        step(1);                                   // P0: IDLE->RUN
        check("run_busy", 32'(busy), 32'd1);
        check("run_wr0",  32'(wr),   32'd0);
        step(1);                                   // P1: header written
        check("hdr_wr",   32'(wr),   32'd1);
        check("hdr_data", data,      32'h8100_0400);
        step(1);                                   // P2
        check("hdr_wr_1cyc", 32'(wr), 32'd0);
        check("hdr_hold",    data,    32'h8100_0400);

        // Lane 1 edge sampled with ts=5.
        step(3);                                   // P5
        mon = 2'b10;
        step(1);                                   // P6: pending set
        check("ev1_wr0", 32'(wr), 32'd0);
        mon = 2'b00;
        step(1);                                   // P7
        check("ev1_wr",   32'(wr), 32'd1);
        check("ev1_data", data,    32'h0101_0005);

        // Both lanes together with ptr=1: lane 0 first, then lane 1.
        mon = 2'b11;
        step(1);                                   // P8
        check("both_wr0", 32'(wr), 32'd0);
        mon = 2'b00;
        step(1);                                   // P9
        check("both_l0", data, 32'h0001_0007);
        check("both_l0_wr", 32'(wr), 32'd1);
        step(1);                                   // P10
        check("both_l1", data, 32'h0102_0007);
        check("both_l1_wr", 32'(wr), 32'd1);
        check("both_drop", 32'(drop), 32'd0);
        step(1);                                   // P11
        check("both_done", 32'(wr), 32'd0);

        // Almost-full held across three lane-0 pulses.
        af = 1'b1; mon = 2'b01;
        step(1);                                   // P12: ts 11
        mon = 2'b00;
        step(1);                                   // P13
        check("af_wr_a", 32'(wr), 32'd0);
        mon = 2'b01;
        step(1);                                   // P14: ts 13, drop
        check("af_drop1", 32'(drop), 32'd1);
        mon = 2'b00;
        step(1);                                   // P15
        mon = 2'b01;
        step(1);                                   // P16: ts 15, drop
        check("af_drop2", 32'(drop), 32'd2);
        check("af_wr_b",  32'(wr),   32'd0);
        mon = 2'b00;
        step(1);                                   // P17
        check("af_wr_c", 32'(wr), 32'd0);
        af = 1'b0;
        step(1);                                   // P18
        check("af_rel_wr",   32'(wr), 32'd1);
        check("af_rel_data", data,    32'h0004_000F);
        step(1);                                   // P19
        check("af_rel_once", 32'(wr), 32'd0);

        // Full blocks writes just like almost-full.
        full = 1'b1; mon = 2'b10;
        step(1);                                   // P20: ts 19
        mon = 2'b00;
        step(1);                                   // P21
        check("full_wr", 32'(wr), 32'd0);
        full = 1'b0;
        step(1);                                   // P22
        check("full_rel_data", data,    32'h0103_0013);
        check("full_rel_wr",   32'(wr), 32'd1);

        // Pending lane then stop: event, trailer, IDLE.
        mon = 2'b01;
        step(1);                                   // P23: ts 22
        mon = 2'b00; enable = 1'b0;
        step(1);                                   // P24: RUN->STOP, event
        check("stop_ev_wr",   32'(wr), 32'd1);
        check("stop_ev_data", data,    32'h0005_0016);
        check("stop_busy",    32'(busy), 32'd1);
        step(1);                                   // P25
        check("stop_gap", 32'(wr), 32'd0);
        step(1);                                   // P26: trailer
        check("trl_wr",   32'(wr), 32'd1);
        check("trl_data", data,    32'hC000_0002);
        check("trl_idle", 32'(busy), 32'd0);
        step(1);                                   // P27
        check("idle_wr",   32'(wr),   32'd0);
        check("idle_drop", 32'(drop), 32'd2);

        // New run clears drops; reset in the middle of the header write.
        enable = 1'b1;
        step(1);                                   // P28
        check("rerun_drop", 32'(drop), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        step(1);                                   // P29
        check("rerun_hdr_wr", 32'(wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wr",   32'(wr),   32'd0);
        check("midrst_data", data,      32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        #3 rst_n = 1'b1;
        enable = 1'b0;

        // Heartbeat instance, period 8.
        en_hb = 1'b1;
        step(1);                                   // Q0: IDLE->RUN
        check("hb_busy", 32'(busy_hb), 32'd1);
        step(1);                                   // Q1
        check("hb_hdr", data_hb, 32'h8100_0008);
        step(7);                                   // Q8
        check("hb_wr0", 32'(wr_hb), 32'd0);
        step(1);                                   // Q9
        check("hb1_wr",   32'(wr_hb), 32'd1);
        check("hb1_data", data_hb,    32'h4000_0008);
        step(1);                                   // Q10
        check("hb1_once", 32'(wr_hb), 32'd0);
        step(7);                                   // Q17
        check("hb2_data", data_hb, 32'h4000_0010);
        step(8);                                   // Q25
        check("hb3_data", data_hb, 32'h4000_0018);
        check("hb3_wr",   32'(wr_hb), 32'd1);
        check("main_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
